// File: rtl/sdr_mod_pkg.sv
// Shared modulation definitions for the IQ symbol mapper and its matching demodulator.
package sdr_mod_pkg;

    localparam int unsigned SYM_W  = 5;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BITS_W = 4;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'b00,
        MOD_QPSK  = 2'b01,
        MOD_16QAM = 2'b10,
        MOD_RSVD  = 2'b11
    } mod_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PREAMBLE = 2'b01,
        ST_DATA     = 2'b10
    } state_e;

    localparam logic signed [SYM_W-1:0] LVL_QPSK   = 5'sd8;
    localparam logic signed [SYM_W-1:0] LVL_QAM_LO = 5'sd4;
    localparam logic signed [SYM_W-1:0] LVL_QAM_HI = 5'sd12;

    // Gray-coded 16QAM axis: 00 -> -12, 01 -> -4, 11 -> +4, 10 -> +12.
    function automatic logic signed [SYM_W-1:0] gray_to_level(input logic [1:0] g);
        logic signed [SYM_W-1:0] lvl;
        case (g)
            2'b00:   lvl = -LVL_QAM_HI;
            2'b01:   lvl = -LVL_QAM_LO;
            2'b11:   lvl = LVL_QAM_LO;
            default: lvl = LVL_QAM_HI;
        endcase
        return lvl;
    endfunction

    function automatic logic [CNT_W-1:0] syms_per_byte(input mod_e m);
        logic [CNT_W-1:0] n;
        case (m)
            MOD_BPSK:  n = 4'd8;
            MOD_QPSK:  n = 4'd4;
            MOD_16QAM: n = 4'd2;
            default:   n = 4'd0;
        endcase
        return n;
    endfunction

    // Drop the bits of the symbol just emitted from the MSB end of the byte.
    function automatic logic [BYTE_W-1:0] shift_sym(input logic [BYTE_W-1:0] sr, input mod_e m);
        logic [BYTE_W-1:0] r;
        case (m)
            MOD_BPSK:  r = {sr[6:0], 1'b0};
            MOD_QPSK:  r = {sr[5:0], 2'b00};
            MOD_16QAM: r = {sr[3:0], 4'b0000};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/iq_level_map.sv
// Combinational symbol mapper: MSB-aligned bit group plus mode to signed I/Q levels.
module iq_level_map
    import sdr_mod_pkg::*;
#(
    parameter int AMP_BPSK = 12
) (
    input  mod_e                          mode_i,
    input  logic [BITS_W-1:0]             bits_i,
    output logic signed [SYM_W-1:0]       i_o,
    output logic signed [SYM_W-1:0]       q_o
);

    localparam logic signed [SYM_W-1:0] AMP_P = SYM_W'(AMP_BPSK);
    localparam logic signed [SYM_W-1:0] AMP_N = SYM_W'(-AMP_BPSK);

    always_comb begin
        i_o = '0;
        q_o = '0;
        case (mode_i)
            MOD_BPSK: begin
                i_o = bits_i[3] ? AMP_P : AMP_N;
            end
            MOD_QPSK: begin
                i_o = bits_i[3] ? LVL_QPSK : -LVL_QPSK;
                q_o = bits_i[2] ? LVL_QPSK : -LVL_QPSK;
            end
            MOD_16QAM: begin
                i_o = gray_to_level(bits_i[3:2]);
                q_o = gray_to_level(bits_i[1:0]);
            end
            default: begin
                i_o = '0;
                q_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/iq_symbol_mapper.sv
// Byte-stream to IQ symbol mapper: preamble insertion, BPSK/QPSK/16QAM mapping, ready/valid handshakes.
module iq_symbol_mapper
    import sdr_mod_pkg::*;
#(
    parameter int unsigned PRE_LEN  = 8,
    parameter int          AMP_BPSK = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mod_sel,
    input  logic [BYTE_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [SYM_W-1:0] i_out,
    output logic signed [SYM_W-1:0] q_out,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic                    sym_first,
    output logic                    mode_err
);

    localparam logic signed [SYM_W-1:0] AMP_P    = SYM_W'(AMP_BPSK);
    localparam logic signed [SYM_W-1:0] AMP_N    = SYM_W'(-AMP_BPSK);
    localparam logic [CNT_W-1:0]        PRE_LAST = CNT_W'(PRE_LEN - 1);

    state_e                   state_q;
    mod_e                     mode_q;
    logic [BYTE_W-1:0]        sr_q;
    logic [CNT_W-1:0]         rem_q;
    logic [CNT_W-1:0]         pre_cnt_q;
    logic                     frame_end_q;
    logic signed [SYM_W-1:0]  i_q;
    logic signed [SYM_W-1:0]  q_q;
    logic                     valid_q;
    logic                     first_q;
    logic                     err_q;

    logic                     xfer_c;
    logic                     advance_c;
    logic                     in_ready_c;
    logic                     accept_c;
    logic [BITS_W-1:0]        map_bits_c;
    logic signed [SYM_W-1:0]  map_i_c;
    logic signed [SYM_W-1:0]  map_q_c;

    // Output register may take a new symbol when empty or when its symbol leaves this cycle.
    always_comb begin
        xfer_c     = valid_q && sym_ready;
        advance_c  = !valid_q || sym_ready;
        in_ready_c = 1'b0;
        if (state_q == ST_DATA && !frame_end_q && rem_q == '0 && advance_c) begin
            in_ready_c = 1'b1;
        end
        accept_c   = in_valid && in_ready_c;
        map_bits_c = accept_c ? in_data[BYTE_W-1 -: BITS_W] : sr_q[BYTE_W-1 -: BITS_W];
    end

    iq_level_map #(
        .AMP_BPSK (AMP_BPSK)
    ) u_map (
        .mode_i (mode_q),
        .bits_i (map_bits_c),
        .i_o    (map_i_c),
        .q_o    (map_q_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MOD_BPSK;
            sr_q        <= '0;
            rem_q       <= '0;
            pre_cnt_q   <= '0;
            frame_end_q <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (mod_sel == MOD_RSVD) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q    <= mod_e'(mod_sel);
                            state_q   <= ST_PREAMBLE;
                            pre_cnt_q <= '0;
                            valid_q   <= 1'b1;
                            first_q   <= 1'b1;
                            i_q       <= AMP_P;
                            q_q       <= '0;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (xfer_c) begin
                        first_q <= 1'b0;
                        if (pre_cnt_q == PRE_LAST) begin
                            state_q <= ST_DATA;
                            valid_q <= 1'b0;
                            i_q     <= '0;
                            q_q     <= '0;
                        end else begin
                            // Next index is pre_cnt_q+1: even indices are positive.
                            pre_cnt_q <= pre_cnt_q + 4'd1;
                            i_q       <= pre_cnt_q[0] ? AMP_P : AMP_N;
                            q_q       <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept_c) begin
                        valid_q     <= 1'b1;
                        i_q         <= map_i_c;
                        q_q         <= map_q_c;
                        sr_q        <= shift_sym(in_data, mode_q);
                        rem_q       <= CNT_W'(syms_per_byte(mode_q) - 4'd1);
                        frame_end_q <= in_last;
                    end else if (advance_c) begin
                        if (rem_q != '0) begin
                            valid_q <= 1'b1;
                            i_q     <= map_i_c;
                            q_q     <= map_q_c;
                            sr_q    <= shift_sym(sr_q, mode_q);
                            rem_q   <= rem_q - 4'd1;
                        end else begin
                            valid_q <= 1'b0;
                            i_q     <= '0;
                            q_q     <= '0;
                            if (frame_end_q) begin
                                state_q     <= ST_IDLE;
                                frame_end_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_c;
    assign i_out     = i_q;
    assign q_out     = q_q;
    assign sym_valid = valid_q;
    assign sym_first = first_q;
    assign mode_err  = err_q;

endmodule
